uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync_ff.sv | 33 +++
 rtl/uart_rx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   - rx_state_e     : receiver FSM states
//   - OversampleRate : baudx16 ticks per bit period
//   - MidSampleTick  : tick index that lands in the middle of the start bit
//   - LastSampleTick : tick index at which data and stop bits are sampled
//   - DataBits       : data bits per frame (only 8 is supported)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OversampleRate = 16;

    // Typed to the 4-bit tick counter so the compares need no resizing.
    localparam logic [3:0] MidSampleTick  = 4'd7;
    localparam logic [3:0] LastSampleTick = 4'd15;

    localparam int DataBits = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer bringing an asynchronous level into clk_i.
// All flops reset to ResetVal (1 for an idle-high serial line).
// Ports:
//   clk_i  in   system clock
//   rst_i  in   synchronous, active-high reset
//   d_i    in   asynchronous input
//   q_o    out  synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int   Stages   = 2,
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] r_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {Stages{ResetVal}};
        end else begin
            r_sync <= {r_sync[Stages-2:0], d_i};
        end
    end

    assign q_o = r_sync[Stages-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling and a one-entry holding register
// using a valid/ready handshake.
// Ports:
//   clk_i           in   system clock, rising edge
//   rst_i           in   synchronous, active-high reset
//   baudx16_tick_i  in   one-cycle enable at 16x the baud rate
//   rx_i            in   asynchronous serial line, idles high
//   rx_data_o       out  received byte (LSB first on the line)
//   rx_valid_o      out  rx_data_o holds an unconsumed byte
//   rx_ready_i      in   consumer accepts the byte when rx_valid_o is high
//   frame_err_o     out  one-cycle pulse when the stop bit samples low
//   overrun_o       out  one-cycle pulse when a good byte is dropped because
//                        the holding register is still full
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DataBits   = uart_pkg::DataBits,
    parameter int SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                baudx16_tick_i,
    input  logic                rx_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                frame_err_o,
    output logic                overrun_o
);

    localparam logic [2:0] LastBit = 3'(DataBits - 1);

    // -------------------------------------------------------------------------
    // Input synchronizer
    // -------------------------------------------------------------------------
    logic w_rx_s;

    sync_ff #(
        .Stages   (SyncStages),
        .ResetVal (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (w_rx_s)
    );

    // -------------------------------------------------------------------------
    // Receiver state
    // -------------------------------------------------------------------------
    rx_state_e           r_state;
    rx_state_e           w_state_next;
    logic [3:0]          r_tcnt;
    logic [3:0]          w_tcnt_next;
    logic [2:0]          r_bcnt;
    logic [2:0]          w_bcnt_next;
    logic [DataBits-1:0] r_shift;
    logic [DataBits-1:0] w_shift_next;

    // Stop-bit outcome strobes, valid only on the stop sampling tick.
    logic w_stop_good;
    logic w_stop_bad;

    // Holding register and status outputs
    logic [DataBits-1:0] r_data;
    logic [DataBits-1:0] w_data_next;
    logic                r_valid;
    logic                w_valid_next;
    logic                r_ferr;
    logic                r_ovr;
    logic                w_ovr_next;
    logic                w_xfer;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RX_IDLE;
            r_tcnt  <= 4'd0;
            r_bcnt  <= 3'd0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_tcnt  <= w_tcnt_next;
            r_bcnt  <= w_bcnt_next;
            r_shift <= w_shift_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Nothing moves without a tick, so a missing tick
    // stalls every counter indefinitely.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tcnt_next  = r_tcnt;
        w_bcnt_next  = r_bcnt;
        w_shift_next = r_shift;
        w_stop_good  = 1'b0;
        w_stop_bad   = 1'b0;

        if (baudx16_tick_i) begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_next = RX_START;
                        w_tcnt_next  = 4'd0;
                    end
                end

                RX_START: begin
                    if (r_tcnt == MidSampleTick) begin
                        w_tcnt_next = 4'd0;
                        if (!w_rx_s) begin
                            w_state_next = RX_DATA;
                            w_bcnt_next  = 3'd0;
                        end else begin
                            // Line went back high before mid start bit:
                            // a glitch, not a frame. Silently give up.
                            w_state_next = RX_IDLE;
                        end
                    end else begin
                        w_tcnt_next = r_tcnt + 4'd1;
                    end
                end

                RX_DATA: begin
                    // Wraps 15 -> 0, which also starts the next bit period.
                    w_tcnt_next = r_tcnt + 4'd1;
                    if (r_tcnt == LastSampleTick) begin
                        // LSB arrives first, so shift in from the top.
                        w_shift_next = {w_rx_s, r_shift[DataBits-1:1]};
                        w_bcnt_next  = r_bcnt + 3'd1;
                        if (r_bcnt == LastBit) begin
                            w_state_next = RX_STOP;
                            w_tcnt_next  = 4'd0;
                        end
                    end
                end

                RX_STOP: begin
                    w_tcnt_next = r_tcnt + 4'd1;
                    if (r_tcnt == LastSampleTick) begin
                        w_state_next = RX_IDLE;
                        w_tcnt_next  = 4'd0;
                        if (w_rx_s) begin
                            w_stop_good = 1'b1;
                        end else begin
                            w_stop_bad = 1'b1;
                        end
                    end
                end

                default: begin
                    w_state_next = RX_IDLE;
                    w_tcnt_next  = 4'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Holding register. A delivery is accepted when the register is empty or
    // is being drained in the same cycle; otherwise the old byte wins and the
    // new one is reported as an overrun.
    // -------------------------------------------------------------------------
    assign w_xfer = r_valid & rx_ready_i;

    always_comb begin
        w_data_next  = r_data;
        w_valid_next = r_valid;
        w_ovr_next   = 1'b0;

        if (w_stop_good) begin
            if (!r_valid || rx_ready_i) begin
                w_data_next  = r_shift;
                w_valid_next = 1'b1;
            end else begin
                w_ovr_next = 1'b1;
            end
        end else if (w_xfer) begin
            w_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_ferr  <= w_stop_bad;
            r_ovr   <= w_ovr_next;
        end
    end

    assign rx_data_o   = r_data;
    assign rx_valid_o  = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;

endmodule
